// File: rtl/ct_idu_rf_ereg_acc_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ct_idu_rf_ereg_acc_bank (with helper gated_clk_cell)
// Brief    : Bank of exception-flag registers (eregs) for FP/vector writeback
//            pipes. Entries are allocated at rename, written by any writeback
//            port, and on retire their flags are ORed into an architectural
//            flag accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock cannot glitch during the high phase.
module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic external_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);
   logic en_bf_latch;
   logic en_af_latch;

   assign en_bf_latch = (global_en & (module_en | local_en)) | external_en;

   // Transparent while the clock is low, holds during the high phase
   always_latch begin
      if (!clk_in) en_af_latch = en_bf_latch;
   end

   assign clk_out = clk_in & (en_af_latch | pad_yy_icg_scan_en);
endmodule

module ct_idu_rf_ereg_acc_bank #(
   parameter int DATA_WIDTH = 6,
   parameter int DEPTH      = 32,
   parameter int IDX_W      = 5,
   parameter int WB_PORTS   = 2
) (
   input  logic                           ereg_top_clk,
   input  logic                           cpurst_b,
   input  logic                           cp0_yy_clk_en,
   input  logic                           cp0_idu_icg_en,
   input  logic                           pad_yy_icg_scan_en,
   input  logic                           x_alloc_vld,
   input  logic [IDX_W-1:0]               x_alloc_idx,
   input  logic [WB_PORTS-1:0]            x_wb_vld,
   input  logic [WB_PORTS*IDX_W-1:0]      x_wb_idx,
   input  logic [WB_PORTS*DATA_WIDTH-1:0] x_wb_data,
   input  logic                           x_retire_vld,
   input  logic [IDX_W-1:0]               x_retire_idx,
   input  logic                           x_flush,
   input  logic                           x_csr_wr_vld,
   input  logic [DATA_WIDTH-1:0]          x_csr_wr_data,
   input  logic [IDX_W-1:0]               x_rd_idx,
   output logic [DATA_WIDTH-1:0]          x_rd_data,
   output logic                           x_rd_wb,
   output logic [DATA_WIDTH-1:0]          x_acc_reg_dout,
   output logic                           x_err_sticky
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_WB    = 2'd2
   } ereg_st_e;

   logic                               entry_clk;
   logic                               entry_clk_en;
   logic                               acc_clk;
   logic                               acc_clk_en;

   logic [DEPTH-1:0][1:0]              st_all;
   logic [DEPTH-1:0][DATA_WIDTH-1:0]   data_all;
   logic [DEPTH-1:0][DATA_WIDTH-1:0]   contrib_all;
   logic [DEPTH-1:0]                   err_all;

   logic [DATA_WIDTH-1:0]              ret_contrib;
   logic [DATA_WIDTH-1:0]              acc_q;
   logic [DATA_WIDTH-1:0]              acc_d;
   logic                               err_q;

   // Entry array only toggles when some entry could change
   assign entry_clk_en = (|x_wb_vld) | x_alloc_vld | x_retire_vld | x_flush;
   assign acc_clk_en   = x_retire_vld | x_csr_wr_vld;

   gated_clk_cell u_entry_icg (
      .clk_in             (ereg_top_clk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_idu_icg_en),
      .local_en           (entry_clk_en),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (entry_clk)
   );

   gated_clk_cell u_acc_icg (
      .clk_in             (ereg_top_clk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_idu_icg_en),
      .local_en           (acc_clk_en),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (acc_clk)
   );

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry
         localparam logic [IDX_W-1:0] C_IDX = IDX_W'(i);

         ereg_st_e              state_q;
         ereg_st_e              state_d;
         logic [DATA_WIDTH-1:0] data_q;
         logic [DATA_WIDTH-1:0] data_d;
         logic [DATA_WIDTH-1:0] wb_data;
         logic [DATA_WIDTH-1:0] contrib;
         logic                  wb_hit;
         logic                  ret_hit;
         logic                  alloc_hit;
         logic                  leaving;
         logic                  err;

         // Merge every writeback port that targets this entry
         always_comb begin
            wb_hit  = 1'b0;
            wb_data = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
               if (x_wb_vld[p] && (x_wb_idx[p*IDX_W +: IDX_W] == C_IDX)) begin
                  wb_hit  = 1'b1;
                  wb_data = wb_data | x_wb_data[p*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end

         // Next state, retire contribution and protocol-violation detection
         always_comb begin
            ret_hit   = x_retire_vld & (x_retire_idx == C_IDX);
            alloc_hit = x_alloc_vld & (x_alloc_idx == C_IDX);
            // Retire wins over flush; both free the entry this cycle
            leaving   = ret_hit | (x_flush & (state_q != ST_IDLE));
            state_d   = state_q;
            data_d    = data_q;
            contrib   = '0;
            err       = 1'b0;

            if (wb_hit && (state_q == ST_IDLE)) err = 1'b1;

            if (ret_hit) begin
               case (state_q)
                  ST_WB:    contrib = data_q | wb_data;
                  ST_ALLOC: begin
                     if (wb_hit) contrib = wb_data;
                     else        err     = 1'b1;
                  end
                  default:  err = 1'b1;
               endcase
            end

            if (alloc_hit) begin
               // Re-allocating a live entry that is not being freed is illegal
               if ((state_q != ST_IDLE) && !leaving) err = 1'b1;
               state_d = ST_ALLOC;
               data_d  = '0;
            end else if (leaving) begin
               state_d = ST_IDLE;
               data_d  = '0;
            end else if (wb_hit && (state_q != ST_IDLE)) begin
               state_d = ST_WB;
               data_d  = data_q | wb_data;
            end
         end

         // Entry state and flag storage on the activity-gated clock
         always_ff @(posedge entry_clk or negedge cpurst_b) begin
            if (!cpurst_b) begin
               state_q <= ST_IDLE;
               data_q  <= '0;
            end else begin
               state_q <= state_d;
               data_q  <= data_d;
            end
         end

         assign st_all[i]      = state_q;
         assign data_all[i]    = data_q;
         assign contrib_all[i] = contrib;
         assign err_all[i]     = err;
      end
   endgenerate

   // Collect retire contributions and form the next accumulator value
   always_comb begin
      ret_contrib = '0;
      for (int e = 0; e < DEPTH; e++) ret_contrib = ret_contrib | contrib_all[e];
      acc_d = (x_csr_wr_vld ? x_csr_wr_data : acc_q) | ret_contrib;
   end

   // Architectural flag accumulator, clocked only on retire or CSR write
   always_ff @(posedge acc_clk or negedge cpurst_b) begin
      if (!cpurst_b) acc_q <= '0;
      else           acc_q <= acc_d;
   end

   // Sticky protocol error on the free-running clock so no event is missed
   always_ff @(posedge ereg_top_clk or negedge cpurst_b) begin
      if (!cpurst_b) err_q <= 1'b0;
      else           err_q <= err_q | (|err_all);
   end

   assign x_rd_wb        = (st_all[x_rd_idx] == ST_WB);
   assign x_rd_data      = {DATA_WIDTH{x_rd_wb}} & data_all[x_rd_idx];
   assign x_acc_reg_dout = acc_q;
   assign x_err_sticky   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_idu_rf_ereg_acc_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ct_idu_rf_ereg_acc_bank
// Brief    : Self-checking bench: directed scenarios then randomized traffic,
//            compared cycle by cycle against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ct_idu_rf_ereg_acc_bank;
   localparam int DW = 6;
   localparam int DEPTH = 32;
   localparam int IW = 5;
   localparam int NP = 2;
   localparam int M_IDLE = 0;
   localparam int M_ALLOC = 1;
   localparam int M_WB = 2;

   logic             clk = 1'b0;
   logic             cpurst_b = 1'b0;
   logic             cp0_yy_clk_en = 1'b1;
   logic             cp0_idu_icg_en = 1'b0;
   logic             pad_yy_icg_scan_en = 1'b0;
   logic             x_alloc_vld = 1'b0;
   logic [IW-1:0]    x_alloc_idx = '0;
   logic [NP-1:0]    x_wb_vld = '0;
   logic [NP*IW-1:0] x_wb_idx = '0;
   logic [NP*DW-1:0] x_wb_data = '0;
   logic             x_retire_vld = 1'b0;
   logic [IW-1:0]    x_retire_idx = '0;
   logic             x_flush = 1'b0;
   logic             x_csr_wr_vld = 1'b0;
   logic [DW-1:0]    x_csr_wr_data = '0;
   logic [IW-1:0]    x_rd_idx = '0;
   logic [DW-1:0]    x_rd_data;
   logic             x_rd_wb;
   logic [DW-1:0]    x_acc_reg_dout;
   logic             x_err_sticky;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model state
   int            m_st [DEPTH];
   logic [DW-1:0] m_dat[DEPTH];
   logic [DW-1:0] m_acc;
   logic          m_err;

   ct_idu_rf_ereg_acc_bank #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IW), .WB_PORTS(NP)
   ) dut (
      .ereg_top_clk       (clk),
      .cpurst_b           (cpurst_b),
      .cp0_yy_clk_en      (cp0_yy_clk_en),
      .cp0_idu_icg_en     (cp0_idu_icg_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .x_alloc_vld        (x_alloc_vld),
      .x_alloc_idx        (x_alloc_idx),
      .x_wb_vld           (x_wb_vld),
      .x_wb_idx           (x_wb_idx),
      .x_wb_data          (x_wb_data),
      .x_retire_vld       (x_retire_vld),
      .x_retire_idx       (x_retire_idx),
      .x_flush            (x_flush),
      .x_csr_wr_vld       (x_csr_wr_vld),
      .x_csr_wr_data      (x_csr_wr_data),
      .x_rd_idx           (x_rd_idx),
      .x_rd_data          (x_rd_data),
      .x_rd_wb            (x_rd_wb),
      .x_acc_reg_dout     (x_acc_reg_dout),
      .x_err_sticky       (x_err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int e = 0; e < DEPTH; e++) begin
         m_st[e]  = M_IDLE;
         m_dat[e] = '0;
      end
      m_acc = '0;
      m_err = 1'b0;
   endtask

   task automatic clear_ops();
      x_alloc_vld = 1'b0; x_wb_vld = '0; x_retire_vld = 1'b0;
      x_flush = 1'b0; x_csr_wr_vld = 1'b0; x_csr_wr_data = '0;
   endtask

   task automatic set_wb(input int p, input int idx, input logic [DW-1:0] d);
      x_wb_vld[p] = 1'b1;
      x_wb_idx[p*IW +: IW] = IW'(idx);
      x_wb_data[p*DW +: DW] = d;
   endtask

   // Apply the current inputs to the model as one clock cycle
   task automatic model_step();
      logic [DW-1:0] contrib;
      logic [DW-1:0] wbd;
      logic          hit, ret, al, leave;
      contrib = '0;
      for (int e = 0; e < DEPTH; e++) begin
         wbd = '0; hit = 1'b0;
         for (int p = 0; p < NP; p++)
            if (x_wb_vld[p] && int'(x_wb_idx[p*IW +: IW]) == e) begin
               hit = 1'b1; wbd = wbd | x_wb_data[p*DW +: DW];
            end
         ret = x_retire_vld && int'(x_retire_idx) == e;
         al  = x_alloc_vld && int'(x_alloc_idx) == e;
         if (hit && m_st[e] == M_IDLE) m_err = 1'b1;
         if (ret) begin
            if (m_st[e] == M_WB) contrib = contrib | m_dat[e] | wbd;
            else if (m_st[e] == M_ALLOC && hit) contrib = contrib | wbd;
            else m_err = 1'b1;
         end
         leave = ret || (x_flush && m_st[e] != M_IDLE);
         if (al) begin
            if (m_st[e] != M_IDLE && !leave) m_err = 1'b1;
            m_st[e] = M_ALLOC; m_dat[e] = '0;
         end else if (leave) begin
            m_st[e] = M_IDLE; m_dat[e] = '0;
         end else if (hit && m_st[e] != M_IDLE) begin
            m_st[e] = M_WB; m_dat[e] = m_dat[e] | wbd;
         end
      end
      m_acc = (x_csr_wr_vld ? x_csr_wr_data : m_acc) | contrib;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      check_eq("acc", 32'(x_acc_reg_dout), 32'(m_acc));
      check_eq("err", 32'(x_err_sticky), 32'(m_err));
      check_eq("rd_wb", 32'(x_rd_wb), 32'(m_st[x_rd_idx] == M_WB));
      check_eq("rd_data", 32'(x_rd_data), (m_st[x_rd_idx] == M_WB) ? 32'(m_dat[x_rd_idx]) : 32'd0);
      clear_ops();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once
   task automatic mid_reset();
      #2 cpurst_b = 1'b0;
      #1;
      check_eq("rst_acc", 32'(x_acc_reg_dout), 32'd0);
      check_eq("rst_err", 32'(x_err_sticky), 32'd0);
      check_eq("rst_rd_wb", 32'(x_rd_wb), 32'd0);
      check_eq("rst_rd_data", 32'(x_rd_data), 32'd0);
      model_reset();
      clear_ops();
      @(posedge clk); #1;
      @(posedge clk); #1;
      cpurst_b = 1'b1;
   endtask

   function automatic int find_entry(input int start, input int want);
      for (int k = 0; k < DEPTH; k++) begin
         int e;
         e = (start + k) % DEPTH;
         if (want == M_IDLE && m_st[e] == M_IDLE) return e;
         if (want == M_ALLOC && m_st[e] != M_IDLE) return e;
         if (want == M_WB && m_st[e] == M_WB) return e;
      end
      return -1;
   endfunction

   task automatic random_cycle(input bit legal);
      int e;
      cp0_idu_icg_en = ($urandom_range(0, 3) == 0);
      x_rd_idx = IW'($urandom_range(0, DEPTH-1));
      if (legal) begin
         if ($urandom_range(0, 2) == 0) begin
            e = find_entry($urandom_range(0, DEPTH-1), M_IDLE);
            if (e >= 0) begin x_alloc_vld = 1'b1; x_alloc_idx = IW'(e); end
         end
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 1) == 1) begin
               e = find_entry($urandom_range(0, DEPTH-1), M_ALLOC);
               if (e >= 0 && !(x_alloc_vld && int'(x_alloc_idx) == e))
                  set_wb(p, e, DW'($urandom));
            end
         if ($urandom_range(0, 9) < 4) begin
            if (x_wb_vld[0] && m_st[x_wb_idx[IW-1:0]] == M_ALLOC && $urandom_range(0, 1) == 1)
               e = int'(x_wb_idx[IW-1:0]);
            else
               e = find_entry($urandom_range(0, DEPTH-1), M_WB);
            if (e >= 0 && !(x_alloc_vld && int'(x_alloc_idx) == e)) begin
               x_retire_vld = 1'b1; x_retire_idx = IW'(e);
            end
         end
         x_flush = ($urandom_range(0, 29) == 0);
      end else begin
         x_alloc_vld = ($urandom_range(0, 2) == 0);
         x_alloc_idx = IW'($urandom_range(0, DEPTH-1));
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 1) == 1) set_wb(p, $urandom_range(0, DEPTH-1), DW'($urandom));
         x_retire_vld = ($urandom_range(0, 2) == 0);
         x_retire_idx = IW'($urandom_range(0, DEPTH-1));
         x_flush = ($urandom_range(0, 19) == 0);
      end
      x_csr_wr_vld = ($urandom_range(0, 19) == 0);
      x_csr_wr_data = DW'($urandom);
      tick();
   endtask

   initial begin
      model_reset();
      #1;
      check_eq("reset_acc", 32'(x_acc_reg_dout), 32'd0);
      check_eq("reset_err", 32'(x_err_sticky), 32'd0);
      check_eq("reset_rd_wb", 32'(x_rd_wb), 32'd0);
      check_eq("reset_rd_data", 32'(x_rd_data), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      cpurst_b = 1'b1;

      // Single-port writeback then retire
      x_rd_idx = 5'd3;
      x_alloc_vld = 1'b1; x_alloc_idx = 5'd3; tick();
      set_wb(0, 3, 6'b000101); tick();
      check_eq("t1_rd_data", 32'(x_rd_data), 32'b000101);
      x_retire_vld = 1'b1; x_retire_idx = 5'd3; tick();
      check_eq("t1_acc", 32'(x_acc_reg_dout), 32'b000101);
      check_eq("t1_rd_wb", 32'(x_rd_wb), 32'd0);

      // Two ports hitting one entry in the same cycle
      x_csr_wr_vld = 1'b1; x_csr_wr_data = '0; tick();
      x_alloc_vld = 1'b1; x_alloc_idx = 5'd7; tick();
      set_wb(0, 7, 6'b000001); set_wb(1, 7, 6'b010000); tick();
      x_retire_vld = 1'b1; x_retire_idx = 5'd7; tick();
      check_eq("t2_acc", 32'(x_acc_reg_dout), 32'b010001);
      check_eq("t2_err", 32'(x_err_sticky), 32'd0);

      // Bypass: writeback and retire of an ALLOC entry together
      x_rd_idx = 5'd9;
      x_alloc_vld = 1'b1; x_alloc_idx = 5'd9; tick();
      set_wb(0, 9, 6'b100000); x_retire_vld = 1'b1; x_retire_idx = 5'd9; tick();
      check_eq("t3_acc", 32'(x_acc_reg_dout), 32'b110001);
      check_eq("t3_rd_wb", 32'(x_rd_wb), 32'd0);
      check_eq("t3_err", 32'(x_err_sticky), 32'd0);

      // Flush with a same-cycle retire: only the retiring entry accumulates
      x_alloc_vld = 1'b1; x_alloc_idx = 5'd1; tick();
      x_alloc_vld = 1'b1; x_alloc_idx = 5'd2; tick();
      set_wb(0, 1, 6'b000010); set_wb(1, 2, 6'b001000); tick();
      x_csr_wr_vld = 1'b1; x_csr_wr_data = '0; tick();
      x_rd_idx = 5'd2;
      x_flush = 1'b1; x_retire_vld = 1'b1; x_retire_idx = 5'd1; tick();
      check_eq("t4_acc", 32'(x_acc_reg_dout), 32'b000010);
      check_eq("t4_rd_wb", 32'(x_rd_wb), 32'd0);
      check_eq("t4_rd_data", 32'(x_rd_data), 32'd0);

      // CSR write coinciding with a retire keeps the retire contribution
      x_csr_wr_vld = 1'b1; x_csr_wr_data = 6'b111111; tick();
      x_alloc_vld = 1'b1; x_alloc_idx = 5'd4; tick();
      set_wb(0, 4, 6'b000100); tick();
      x_csr_wr_vld = 1'b1; x_csr_wr_data = '0;
      x_retire_vld = 1'b1; x_retire_idx = 5'd4; tick();
      check_eq("t5_acc", 32'(x_acc_reg_dout), 32'b000100);

      // Retire of an IDLE entry raises the sticky error
      x_retire_vld = 1'b1; x_retire_idx = 5'd5; tick();
      check_eq("t6_acc", 32'(x_acc_reg_dout), 32'b000100);
      check_eq("t6_err", 32'(x_err_sticky), 32'd1);
      tick(); tick();
      check_eq("t6_err_hold", 32'(x_err_sticky), 32'd1);
      mid_reset();

      // Randomized legal traffic, then unconstrained traffic
      for (int c = 0; c < 1500; c++) random_cycle(1'b1);
      for (int c = 0; c < 1500; c++) random_cycle(1'b0);
      mid_reset();
      for (int c = 0; c < 300; c++) random_cycle(1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
